id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  Decode->execute pipeline stage. Sits directly downstream of the register file.
//  Captures rs1/rs2 read data, immediate, rd, PC and control bits for one instruction.
//  Presents them to the execute stage through a valid/ready handshake.
//  Holds a 2-entry skid buffer (main + skid), so in_ready is a registered signal
//  and throughput stays at 1 instr/cycle.
// PARAMETERS
//  D_WIDTH        32  data/PC/immediate width
//  ADDRESS_WIDTH  5   register index width
//  CTRL_W         12  width of opaque decoded-control bundle
// PORTS
//  clk          in   1              clock, all state updates on posedge
//  rst_n        in   1              async active-low reset
//  flush        in   1              kill all held entries (branch mispredict/trap)
//  in_valid     in   1              decode presents an instruction
//  in_ready     out  1              stage can accept (registered)
//  in_pc        in   D_WIDTH        instruction PC
//  in_rs1       in   ADDRESS_WIDTH  source reg 1 index
//  in_rs2       in   ADDRESS_WIDTH  source reg 2 index
//  in_rd        in   ADDRESS_WIDTH  destination index
//  in_rs1_data  in   D_WIDTH        reg file read data 1
//  in_rs2_data  in   D_WIDTH        reg file read data 2
//  in_imm       in   D_WIDTH        sign-extended immediate
//  in_ctrl      in   CTRL_W         decoded control
//  out_valid    out  1              main entry valid to execute
//  out_ready    in   1              execute accepts
//  out_pc/out_rs1/out_rs2/out_rd/out_rs1_data/out_rs2_data/out_imm/out_ctrl
//               out  as in_*        main entry fields
//  wb_en        in   1              writeback writes reg file this cycle
//  wb_rd        in   ADDRESS_WIDTH  writeback destination
//  wb_data      in   D_WIDTH        writeback value
//  occupancy    out  2              entries held (0..2)
// BEHAVIOUR
//  - Reset (async, rst_n=0): main/skid valid=0, all data fields 0.
//    out_valid=0, in_ready=1, occupancy=0.
//  - accept = in_valid & in_ready; fire = out_valid & out_ready.
//    Latency accept->out_valid = 1 cycle.
//  - FSM, state = occupancy:
//      EMPTY: accept -> ONE (load main).
//      ONE:   accept & fire  -> ONE (main <= in).
//             accept & !fire -> TWO (skid <= in).
//             !accept & fire -> EMPTY.
//      TWO:   in_ready=0; fire -> ONE (main <= skid); else hold.
//  - in_ready = !(next state == TWO), registered; no comb path from out_ready.
//  - Output fields are driven only from main; out_valid = (state != EMPTY).
//  - Ordering is strictly FIFO; skid is never presented ahead of main.
//  - flush: next state EMPTY, in_ready=1.
//    Entry offered in the flush cycle is dropped.
//    A fire in the flush cycle is still a valid transfer.
//    flush has priority over accept.
//  - out_* are X-free but don't-care while out_valid=0.
//    Data regs are not cleared on flush.
//  - rs index 0: data is passed through as delivered (reg file returns 0).
// CONFIGURATION
//  RF_BYPASS_EN defined:
//    - Each held entry with wb_en & wb_rd!=0 & wb_rd==rsN updates
//      rsN_data <= wb_data at posedge, where N = 1 or 2, both independently.
//    - Applies to the entry moving skid->main in the same cycle.
//    - Does not apply to the entry being accepted this cycle
//      (the reg file negedge write already covers it).
//  RF_BYPASS_EN undefined:
//    - wb_* ports are ignored; held operands never change.
//    - Upstream hazard logic must stall instead.
// STRUCTURE
//  - Package pipe_pkg: id_ex_t packed struct (pc, rs1, rs2, rd, rs1_data,
//    rs2_data, imm, ctrl) and typedef enum logic[1:0] {EMPTY, ONE, TWO} skid_state_t.
//  - Sub-module id_ex_bypass: one id_ex_t in, wb_* in, updated id_ex_t out.
//    Combinational; instantiated once per held entry under RF_BYPASS_EN.
// TESTING
//  1. Reset mid-stream with occupancy=2 -> out_valid=0, in_ready=1,
//     occupancy=0 asynchronously.
//  2. in_valid=1 and out_ready=1 for 8 cycles, PCs 0x0..0x1C ->
//     out PCs 0x0..0x1C in order, one per cycle, 1-cycle latency.
//  3. out_ready=0 while sending PC 0x10,0x14,0x18 -> occupancy=2,
//     in_ready=0 after 2 accepts, 0x18 held off.
//     Release -> 0x10,0x14,0x18 in order, none lost.
//  4. flush with occupancy=2 and in_valid=1 (PC 0x40) ->
//     next cycle out_valid=0, 0x40 never emitted.
//  5. RF_BYPASS_EN: held entry rs1=5, rs1_data=0x1; wb_en, wb_rd=5,
//     wb_data=0xDEAD -> out_rs1_data=0xDEAD next cycle.
//     wb_rd=0 -> unchanged.
//  6. RF_BYPASS_EN off: same stimulus as 5 -> out_rs1_data stays 0x1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the decode->execute boundary: the captured instruction
// record and the occupancy-encoded skid-buffer state.
package pipe_pkg;

  localparam int unsigned PIPE_D_W    = 32;
  localparam int unsigned PIPE_ADDR_W = 5;
  localparam int unsigned PIPE_CTRL_W = 12;

  typedef struct packed {
    logic [PIPE_D_W-1:0]    pc;
    logic [PIPE_ADDR_W-1:0] rs1;
    logic [PIPE_ADDR_W-1:0] rs2;
    logic [PIPE_ADDR_W-1:0] rd;
    logic [PIPE_D_W-1:0]    rs1_data;
    logic [PIPE_D_W-1:0]    rs2_data;
    logic [PIPE_D_W-1:0]    imm;
    logic [PIPE_CTRL_W-1:0] ctrl;
  } id_ex_t;

  // Encoding equals the number of held entries so it drives occupancy directly.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/id_ex_bypass.sv
// Writeback forwarding into one held entry: replaces rs1/rs2 operand data when
// the register being written matches (x0 excluded). Purely combinational.
module id_ex_bypass
  import pipe_pkg::*;
(
  input  id_ex_t                 e_in,
  input  logic                   wb_en,
  input  logic [PIPE_ADDR_W-1:0] wb_rd,
  input  logic [PIPE_D_W-1:0]    wb_data,
  output id_ex_t                 e_out
);

  logic wb_live;

  assign wb_live = wb_en && (wb_rd != '0);

  always_comb begin
    e_out = e_in;
    if (wb_live && (wb_rd == e_in.rs1)) e_out.rs1_data = wb_data;
    if (wb_live && (wb_rd == e_in.rs2)) e_out.rs2_data = wb_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode->execute stage with a 2-entry (main + skid) buffer and registered
// in_ready. Optional writeback forwarding into held entries via `RF_BYPASS_EN.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned D_WIDTH       = 32,
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned CTRL_W        = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [D_WIDTH-1:0]       in_pc,
  input  logic [ADDRESS_WIDTH-1:0] in_rs1,
  input  logic [ADDRESS_WIDTH-1:0] in_rs2,
  input  logic [ADDRESS_WIDTH-1:0] in_rd,
  input  logic [D_WIDTH-1:0]       in_rs1_data,
  input  logic [D_WIDTH-1:0]       in_rs2_data,
  input  logic [D_WIDTH-1:0]       in_imm,
  input  logic [CTRL_W-1:0]        in_ctrl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [D_WIDTH-1:0]       out_pc,
  output logic [ADDRESS_WIDTH-1:0] out_rs1,
  output logic [ADDRESS_WIDTH-1:0] out_rs2,
  output logic [ADDRESS_WIDTH-1:0] out_rd,
  output logic [D_WIDTH-1:0]       out_rs1_data,
  output logic [D_WIDTH-1:0]       out_rs2_data,
  output logic [D_WIDTH-1:0]       out_imm,
  output logic [CTRL_W-1:0]        out_ctrl,
  input  logic                     wb_en,
  input  logic [ADDRESS_WIDTH-1:0] wb_rd,
  input  logic [D_WIDTH-1:0]       wb_data,
  output logic [1:0]               occupancy
);

  skid_state_t state_q, state_d;
  id_ex_t      main_q, main_d, skid_q, skid_d;
  id_ex_t      main_byp, skid_byp, in_entry;
  logic        in_ready_q, in_ready_d;
  logic        accept, fire;

  assign in_entry = '{pc: in_pc, rs1: in_rs1, rs2: in_rs2, rd: in_rd,
                      rs1_data: in_rs1_data, rs2_data: in_rs2_data,
                      imm: in_imm, ctrl: in_ctrl};

`ifdef RF_BYPASS_EN
  id_ex_bypass u_byp_main (
    .e_in    (main_q),
    .wb_en   (wb_en),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .e_out   (main_byp)
  );

  id_ex_bypass u_byp_skid (
    .e_in    (skid_q),
    .wb_en   (wb_en),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .e_out   (skid_byp)
  );
`else
  logic unused_wb;

  assign unused_wb = ^{wb_en, wb_rd, wb_data};
  assign main_byp  = main_q;
  assign skid_byp  = skid_q;
`endif

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign fire      = out_valid && out_ready;

  // Held entries always take the forwarded copy; only a freshly accepted
  // entry bypasses forwarding, since the reg file read already saw the write.
  always_comb begin
    state_d = state_q;
    main_d  = main_byp;
    skid_d  = skid_byp;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_entry;
          end
        end
        ONE: begin
          if (accept && fire) begin
            main_d = in_entry;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = in_entry;
          end else if (fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (fire) begin
            state_d = ONE;
            main_d  = skid_byp;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign occupancy    = state_q;
  assign out_pc       = main_q.pc;
  assign out_rs1      = main_q.rs1;
  assign out_rs2      = main_q.rs2;
  assign out_rd       = main_q.rd;
  assign out_rs1_data = main_q.rs1_data;
  assign out_rs2_data = main_q.rs2_data;
  assign out_imm      = main_q.imm;
  assign out_ctrl     = main_q.ctrl;

endmodule
